// File: rtl/ttt_game_ctrl.sv
// ttt_game_ctrl
// Sequencing controller for a single tic-tac-toe game between X and O.
// It alternates turns, accepts or rejects moves through a valid/ready
// handshake, keeps one 9-bit occupancy board per player, and decides
// win / tie / forfeit.
//
// Handshake: a move transfers on a rising edge where move_valid and
// move_ready are both high. move_ready is high only while a player holds
// the turn. The response (move_ack or move_err) is a one-cycle pulse in
// the following cycle. The requester may hold move_valid; move_ready
// drops during the evaluation cycle, so a held request is not taken twice.
//
// Ports:
//   clk, rst          : clock (rising edge), asynchronous active-high reset
//   start             : one-cycle pulse, aborts any game and starts a new one
//   move_valid        : move request present
//   move_player       : requesting player (0 = X, 1 = O)
//   move_cell         : cell index 0..8 (bit n of a board is cell n)
//   move_ready        : a player holds the turn and moves are accepted
//   move_ack/move_err : one-cycle pulse, move accepted / rejected
//   board_x, board_o  : occupancy boards
//   turn              : player whose turn it is (valid while move_ready)
//   move_count        : accepted moves in the current game, 0..9
//   game_over         : a terminal state (X win, O win, tie) is held
//   winner            : 00 none, 01 X, 10 O, 11 tie
//   dbg_state         : current FSM state encoding, for observation only
module ttt_game_ctrl #(
    parameter bit          FIRST_PLAYER = 1'b0,
    parameter int unsigned TURN_TIMEOUT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       move_valid,
    input  logic       move_player,
    input  logic [3:0] move_cell,
    output logic       move_ready,
    output logic       move_ack,
    output logic       move_err,
    output logic [8:0] board_x,
    output logic [8:0] board_o,
    output logic       turn,
    output logic [3:0] move_count,
    output logic       game_over,
    output logic [1:0] winner,
    output logic [2:0] dbg_state
);

    localparam int          TW         = 24;
    localparam logic [TW-1:0] TIMER_INIT = TW'(TURN_TIMEOUT);
    localparam bit          TIMER_EN   = (TURN_TIMEOUT != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_X_TURN = 3'd1,
        S_O_TURN = 3'd2,
        S_CHECK  = 3'd3,
        S_X_WIN  = 3'd4,
        S_O_WIN  = 3'd5,
        S_TIE    = 3'd6
    } state_t;

    state_t          state_q, state_d;
    logic [8:0]      board_x_q, board_x_d;
    logic [8:0]      board_o_q, board_o_d;
    logic [3:0]      count_q, count_d;
    logic            turn_q, turn_d;
    logic [1:0]      winner_q, winner_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            ack_q, ack_d;
    logic            err_q, err_d;
    logic            ready_q, ready_d;
    logic            over_q, over_d;

    // Any of the eight lines fully occupied in one board.
    function automatic logic has_line(input logic [8:0] b);
        return (b[8] & b[7] & b[6]) | (b[5] & b[4] & b[3]) | (b[2] & b[1] & b[0]) |
               (b[8] & b[5] & b[2]) | (b[7] & b[4] & b[1]) | (b[6] & b[3] & b[0]) |
               (b[8] & b[4] & b[0]) | (b[6] & b[4] & b[2]);
    endfunction

    logic [8:0] cell_mask;
    logic       cell_in_range;
    logic       move_legal;
    logic       expired;
    logic [8:0] mover_board;

    always_comb begin
        cell_in_range = (move_cell <= 4'd8);
        // Cells 9..15 shift out of range and give an empty mask.
        cell_mask     = 9'(1) << move_cell;
        move_legal    = (move_player == turn_q) && cell_in_range &&
                        ((cell_mask & (board_x_q | board_o_q)) == 9'd0);
        expired       = TIMER_EN && (timer_q == '0);
        mover_board   = turn_q ? board_o_q : board_x_q;
    end

    always_comb begin
        state_d   = state_q;
        board_x_d = board_x_q;
        board_o_d = board_o_q;
        count_d   = count_q;
        turn_d    = turn_q;
        winner_d  = winner_q;
        timer_d   = timer_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            S_X_TURN, S_O_TURN: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - 1'b1;
                end
                if (move_valid && move_legal) begin
                    // A legal move on the expiry cycle beats the forfeit.
                    if (turn_q) board_o_d = board_o_q | cell_mask;
                    else        board_x_d = board_x_q | cell_mask;
                    count_d = count_q + 4'd1;
                    ack_d   = 1'b1;
                    state_d = S_CHECK;
                end else begin
                    if (move_valid) begin
                        err_d = 1'b1;
                    end
                    if (expired) begin
                        if (state_q == S_X_TURN) begin
                            state_d  = S_O_WIN;
                            winner_d = 2'b10;
                        end else begin
                            state_d  = S_X_WIN;
                            winner_d = 2'b01;
                        end
                    end
                end
            end
            S_CHECK: begin
                // Only the player who just moved can have completed a line.
                if (has_line(mover_board)) begin
                    state_d  = turn_q ? S_O_WIN : S_X_WIN;
                    winner_d = turn_q ? 2'b10 : 2'b01;
                end else if (count_q == 4'd9) begin
                    state_d  = S_TIE;
                    winner_d = 2'b11;
                end else begin
                    turn_d  = ~turn_q;
                    state_d = turn_q ? S_X_TURN : S_O_TURN;
                    timer_d = TIMER_INIT;
                end
            end
            default: begin
                // IDLE and terminal states hold until start.
            end
        endcase

        // start overrides anything decided above, including a same-cycle move.
        if (start) begin
            board_x_d = 9'd0;
            board_o_d = 9'd0;
            count_d   = 4'd0;
            winner_d  = 2'b00;
            timer_d   = TIMER_INIT;
            turn_d    = FIRST_PLAYER;
            ack_d     = 1'b0;
            err_d     = 1'b0;
            state_d   = FIRST_PLAYER ? S_O_TURN : S_X_TURN;
        end

        ready_d = (state_d == S_X_TURN) || (state_d == S_O_TURN);
        over_d  = (state_d == S_X_WIN) || (state_d == S_O_WIN) || (state_d == S_TIE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            board_x_q <= 9'd0;
            board_o_q <= 9'd0;
            count_q   <= 4'd0;
            turn_q    <= FIRST_PLAYER;
            winner_q  <= 2'b00;
            timer_q   <= TIMER_INIT;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            ready_q   <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            board_x_q <= board_x_d;
            board_o_q <= board_o_d;
            count_q   <= count_d;
            turn_q    <= turn_d;
            winner_q  <= winner_d;
            timer_q   <= timer_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            ready_q   <= ready_d;
            over_q    <= over_d;
        end
    end

    assign move_ready = ready_q;
    assign move_ack   = ack_q;
    assign move_err   = err_q;
    assign board_x    = board_x_q;
    assign board_o    = board_o_q;
    assign turn       = turn_q;
    assign move_count = count_q;
    assign game_over  = over_q;
    assign winner     = winner_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Testbench for ttt_game_ctrl: directed game scripts against a no-timeout
// instance (scoreboard of move responses and game results), plus a second
// instance with a 4-cycle turn timeout.
module tb_ttt_game_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // main instance, no timeout
  logic       start, move_valid, move_player;
  logic [3:0] move_cell;
  logic       move_ready, move_ack, move_err, turn, game_over;
  logic [8:0] board_x, board_o;
  logic [3:0] move_count;
  logic [1:0] winner;
  logic [2:0] dbg_state;

  // timeout instance
  logic       t_start, t_valid, t_player;
  logic [3:0] t_cell;
  logic       t_ready, t_ack, t_err, t_turn, t_game_over;
  logic [8:0] t_board_x, t_board_o;
  logic [3:0] t_count;
  logic [1:0] t_winner;
  logic [2:0] t_dbg_state;

  ttt_game_ctrl #(.FIRST_PLAYER(1'b0), .TURN_TIMEOUT(0)) dut (
    .clk(clk), .rst(rst), .start(start),
    .move_valid(move_valid), .move_player(move_player), .move_cell(move_cell),
    .move_ready(move_ready), .move_ack(move_ack), .move_err(move_err),
    .board_x(board_x), .board_o(board_o), .turn(turn),
    .move_count(move_count), .game_over(game_over), .winner(winner),
    .dbg_state(dbg_state)
  );

  ttt_game_ctrl #(.FIRST_PLAYER(1'b0), .TURN_TIMEOUT(4)) dut_t (
    .clk(clk), .rst(rst), .start(t_start),
    .move_valid(t_valid), .move_player(t_player), .move_cell(t_cell),
    .move_ready(t_ready), .move_ack(t_ack), .move_err(t_err),
    .board_x(t_board_x), .board_o(t_board_o), .turn(t_turn),
    .move_count(t_count), .game_over(t_game_over), .winner(t_winner),
    .dbg_state(t_dbg_state)
  );

  // ---------------- scoreboard state ----------------
  localparam int W = 23;  // {err, board_x, board_o, move_count}
  logic [W-1:0] exp_q[$];
  logic [1:0]   win_q[$];
  int n_checks = 0;
  int n_fail = 0;

  // bench-side board tracking for the main instance
  logic [8:0] mx, mo;
  logic [3:0] mcnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},   32'(move_ready), 32'(0));
    check({tag, "_ack"},     32'(move_ack),   32'(0));
    check({tag, "_err"},     32'(move_err),   32'(0));
    check({tag, "_board_x"}, 32'(board_x),    32'(0));
    check({tag, "_board_o"}, 32'(board_o),    32'(0));
    check({tag, "_count"},   32'(move_count), 32'(0));
    check({tag, "_over"},    32'(game_over),  32'(0));
    check({tag, "_winner"},  32'(winner),     32'(0));
    check({tag, "_turn"},    32'(turn),       32'(0));
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    start = 1'b1;
    mx = 9'd0; mo = 9'd0; mcnt = 4'd0;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for move_ready, registers the expected response, presents the move
  // for exactly one rising edge. Returns on the negedge where the response
  // pulse is visible.
  task automatic drive_move(input logic p, input logic [3:0] c, input logic exp_err);
    int n;
    logic [8:0] m;
    n = 0;
    while (!move_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!move_ready) begin
      check("ready_wait", 32'(move_ready), 32'(1));
      return;
    end
    if (!exp_err) begin
      m = 9'(1) << c;
      if (p) mo = mo | m;
      else   mx = mx | m;
      mcnt = mcnt + 4'd1;
    end
    exp_q.push_back({exp_err, mx, mo, mcnt});
    move_valid  = 1'b1;
    move_player = p;
    move_cell   = c;
    @(negedge clk);
    move_valid  = 1'b0;
  endtask

  // ---------------- monitor ----------------
  logic [W-1:0] mon_e;
  logic [1:0]   mon_w;
  logic         go_prev = 1'b0;

  always @(negedge clk) begin
    if (move_ack || move_err) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL resp_unexpected: got ack=%0d err=%0d expected no response at %0t",
                 move_ack, move_err, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("resp", 32'({move_ack, move_err, board_x, board_o, move_count}),
              32'({~mon_e[W-1], mon_e}));
      end
    end
    if (game_over && !go_prev) begin
      if (win_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL game_end_unexpected: got winner=%0d expected game running at %0t",
                 winner, $time);
      end else begin
        mon_w = win_q.pop_front();
        check("game_winner", 32'(winner), 32'(mon_w));
      end
    end
    go_prev <= game_over;
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    start = 1'b0; move_valid = 1'b0; move_player = 1'b0; move_cell = 4'd0;
    t_start = 1'b0; t_valid = 1'b0; t_player = 1'b0; t_cell = 4'd0;
    mx = 9'd0; mo = 9'd0; mcnt = 4'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    // --- X-first top-row win ---
    pulse_start();
    check("start_ready", 32'(move_ready), 32'(1));
    check("start_turn",  32'(turn),       32'(0));
    win_q.push_back(2'b01);
    drive_move(1'b0, 4'd8, 1'b0);
    check("check_ready_low", 32'(move_ready), 32'(0));
    @(negedge clk);
    check("next_turn_ready", 32'(move_ready), 32'(1));
    check("next_turn_is_o",  32'(turn),       32'(1));
    drive_move(1'b1, 4'd0, 1'b0);
    drive_move(1'b0, 4'd7, 1'b0);
    drive_move(1'b1, 4'd1, 1'b0);
    drive_move(1'b0, 4'd6, 1'b0);
    @(negedge clk);
    check("win_over",    32'(game_over),  32'(1));
    check("win_winner",  32'(winner),     32'(1));
    check("win_board_x", 32'(board_x),    32'(9'h1C0));
    check("win_board_o", 32'(board_o),    32'(9'h003));
    check("win_count",   32'(move_count), 32'(5));
    check("win_ready",   32'(move_ready), 32'(0));

    // --- tie ---
    pulse_start();
    check("tie_restart_winner", 32'(winner), 32'(0));
    win_q.push_back(2'b11);
    drive_move(1'b0, 4'd4, 1'b0);
    drive_move(1'b1, 4'd8, 1'b0);
    drive_move(1'b0, 4'd2, 1'b0);
    drive_move(1'b1, 4'd6, 1'b0);
    drive_move(1'b0, 4'd7, 1'b0);
    drive_move(1'b1, 4'd1, 1'b0);
    drive_move(1'b0, 4'd3, 1'b0);
    drive_move(1'b1, 4'd5, 1'b0);
    drive_move(1'b0, 4'd0, 1'b0);
    @(negedge clk);
    check("tie_winner", 32'(winner),            32'(3));
    check("tie_over",   32'(game_over),         32'(1));
    check("tie_full",   32'(board_x | board_o), 32'(9'h1FF));
    check("tie_count",  32'(move_count),        32'(9));

    // --- illegal moves ---
    pulse_start();
    drive_move(1'b1, 4'd0, 1'b1);   // O during X_TURN
    drive_move(1'b0, 4'd9, 1'b1);   // cell out of range
    drive_move(1'b0, 4'd4, 1'b0);
    drive_move(1'b1, 4'd0, 1'b0);
    drive_move(1'b0, 4'd4, 1'b1);   // occupied by X
    drive_move(1'b0, 4'd0, 1'b1);   // occupied by O
    check("illegal_turn",    32'(turn),       32'(0));
    check("illegal_board_x", 32'(board_x),    32'(9'h010));
    check("illegal_board_o", 32'(board_o),    32'(9'h001));
    check("illegal_count",   32'(move_count), 32'(2));
    check("illegal_ready",   32'(move_ready), 32'(1));

    // --- start during O_TURN, with a legal O move in the same cycle ---
    drive_move(1'b0, 4'd8, 1'b0);
    @(negedge clk);
    check("mid_o_turn",  32'(turn),       32'(1));
    check("mid_count",   32'(move_count), 32'(3));
    start = 1'b1; move_valid = 1'b1; move_player = 1'b1; move_cell = 4'd2;
    mx = 9'd0; mo = 9'd0; mcnt = 4'd0;
    @(negedge clk);
    start = 1'b0; move_valid = 1'b0;
    check("restart_board_x", 32'(board_x),    32'(0));
    check("restart_board_o", 32'(board_o),    32'(0));
    check("restart_count",   32'(move_count), 32'(0));
    check("restart_turn",    32'(turn),       32'(0));
    check("restart_ready",   32'(move_ready), 32'(1));

    // --- asynchronous reset mid-game ---
    drive_move(1'b0, 4'd4, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;
    mx = 9'd0; mo = 9'd0; mcnt = 4'd0;
    move_valid = 1'b1; move_player = 1'b0; move_cell = 4'd0;
    repeat (3) @(negedge clk);
    move_valid = 1'b0;
    check("post_rst_ready", 32'(move_ready), 32'(0));
    check("post_rst_count", 32'(move_count), 32'(0));
    check("post_rst_board", 32'(board_x),    32'(0));

    // --- timeout instance: forfeit with no moves ---
    t_start = 1'b1;
    @(negedge clk);
    t_start = 1'b0;
    repeat (4) @(negedge clk);
    check("to_before_ready", 32'(t_ready),     32'(1));
    check("to_before_over",  32'(t_game_over), 32'(0));
    @(negedge clk);
    check("to_forfeit_winner", 32'(t_winner),    32'(2));
    check("to_forfeit_over",   32'(t_game_over), 32'(1));
    check("to_forfeit_ready",  32'(t_ready),     32'(0));

    // --- timeout instance: legal move on the expiry cycle ---
    t_start = 1'b1;
    @(negedge clk);
    t_start = 1'b0;
    repeat (4) @(negedge clk);
    check("to2_before_over", 32'(t_game_over), 32'(0));
    t_valid = 1'b1; t_player = 1'b0; t_cell = 4'd4;
    @(negedge clk);
    t_valid = 1'b0;
    check("to2_ack",     32'(t_ack),     32'(1));
    check("to2_board_x", 32'(t_board_x), 32'(9'h010));
    check("to2_winner",  32'(t_winner),  32'(0));
    @(negedge clk);
    check("to2_o_ready", 32'(t_ready),     32'(1));
    check("to2_o_turn",  32'(t_turn),      32'(1));
    check("to2_no_over", 32'(t_game_over), 32'(0));

    // --- drain ---
    repeat (3) @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'(0));
    check("win_q_drained", 32'(win_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
